// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared types and constants for the RV32 execute stage
package exu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_ITYPE  = 2'b11
    } alu_cls_e;

endpackage

// File: rtl/exu_op_decode.sv
// rtl/exu_op_decode.sv - alu_op/funct73 to ALU operation code decoder
module exu_op_decode
    import exu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [3:0] funct73,
    output logic [3:0] operation
);

    logic [3:0] fsel;

    always_comb begin
        fsel = funct73;
        // I-type carries instr[30] as immediate bits except for the SRLI/SRAI pair
        if (alu_op == CLS_ITYPE && funct73[2:0] != 3'b101) begin
            fsel = {1'b0, funct73[2:0]};
        end

        operation = OP_ADD;
        case (alu_op)
            CLS_MEM:    operation = OP_ADD;
            CLS_BRANCH: operation = OP_SUB;
            default: begin
                case (fsel)
                    4'b0000: operation = OP_ADD;
                    4'b1000: operation = OP_SUB;
                    4'b0001: operation = OP_SLL;
                    4'b0010: operation = OP_SLT;
                    4'b0011: operation = OP_SLTU;
                    4'b0100: operation = OP_XOR;
                    4'b0101: operation = OP_SRL;
                    4'b1101: operation = OP_SRA;
                    4'b0110: operation = OP_OR;
                    4'b0111: operation = OP_AND;
                    default: operation = OP_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/exu_stage.sv
// rtl/exu_stage.sv - RV32 execute stage: decode, ALU, branch target, EX/MEM regs; shifter gated by EXU_SHIFT_EN
module exu_stage
    import exu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [3:0]      funct73,
    input  logic            alu_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [3:0]      operation,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] alu_result_q,
    output logic [XLEN-1:0] store_data_q
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;

    exu_op_decode u_op_decode (
        .alu_op    (alu_op),
        .funct73   (funct73),
        .operation (operation)
    );

    assign a = rs1_data;
    assign b = alu_src ? imm : rs2_data;

    always_comb begin
        alu_result = '0;
        case (operation)
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_ADD:  alu_result = a + b;
            OP_XOR:  alu_result = a ^ b;
            OP_SUB:  alu_result = a - b;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef EXU_SHIFT_EN
            OP_SLL:  alu_result = a << b[4:0];
            OP_SRL:  alu_result = a >> b[4:0];
            OP_SRA:  alu_result = $unsigned($signed(a) >>> b[4:0]);
`endif
            default: alu_result = '0;
        endcase
    end

    assign zero          = (alu_result == '0);
    assign branch_target = pc + imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            store_data_q <= '0;
        end else begin
            alu_result_q <= alu_result;
            store_data_q <= rs2_data;
        end
    end

endmodule

// File: tb/tb_exu_stage.sv
// tb/tb_exu_stage.sv - directed self-checking bench for exu_stage; shift expectations follow EXU_SHIFT_EN
module tb_exu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  alu_op = 2'b00;
    logic [3:0]  funct73 = 4'b0000;
    logic        alu_src = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic [3:0]  operation;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] branch_target;
    logic [31:0] alu_result_q;
    logic [31:0] store_data_q;

    int n_checks = 0;
    int n_pass   = 0;

    exu_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_op        (alu_op),
        .funct73       (funct73),
        .alu_src       (alu_src),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .pc            (pc),
        .operation     (operation),
        .alu_result    (alu_result),
        .zero          (zero),
        .branch_target (branch_target),
        .alu_result_q  (alu_result_q),
        .store_data_q  (store_data_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic src,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p);
        @(negedge clk);
        alu_op = op; funct73 = f; alu_src = src;
        rs1_data = a; rs2_data = b; imm = i; pc = p;
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [3:0] exp_op, input logic [31:0] exp_res);
        check({tag, "_op"},   {28'b0, operation}, {28'b0, exp_op});
        check({tag, "_res"},  alu_result, exp_res);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'h0)});
    endtask

    logic [31:0] exp_sra;
    logic [31:0] exp_srl;
    logic [31:0] exp_sll;

    initial begin
`ifdef EXU_SHIFT_EN
        exp_sra = 32'hF800_0000;
        exp_srl = 32'h0800_0000;
        exp_sll = 32'h0000_0010;
`else
        exp_sra = 32'h0;
        exp_srl = 32'h0;
        exp_sll = 32'h0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_alu_q", alu_result_q, 32'h0);
        check("reset_store_q", store_data_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type SUB
        drive(2'b10, 4'b1000, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
        check_alu("rsub", 4'b0110, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("rsub_q", alu_result_q, 32'hFFFF_FFFE);
        check("rsub_store_q", store_data_q, 32'd7);

        // Branch compare and target
        drive(2'b01, 4'b0000, 1'b0, 32'h1234, 32'h1234, 32'hFFFF_FFF8, 32'h100);
        check_alu("branch", 4'b0110, 32'h0);
        check("branch_target", branch_target, 32'h0000_00F8);

        // Load/store address, funct73 ignored
        drive(2'b00, 4'b1000, 1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h4, 32'h200);
        check_alu("ldst", 4'b0010, 32'h1004);
        check("ldst_target", branch_target, 32'h204);
        @(posedge clk); #1;
        check("ldst_q", alu_result_q, 32'h1004);
        check("ldst_store_q", store_data_q, 32'hDEAD_BEEF);

        // Asynchronous reset mid-run, away from any edge
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alu_q", alu_result_q, 32'h0);
        check("async_rst_store_q", store_data_q, 32'h0);
        check_alu("rst_comb", 4'b0010, 32'h1004);
        drive(2'b10, 4'b0000, 1'b0, 32'd1, 32'hCAFE_F00D, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("held_rst_alu_q", alu_result_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", alu_result_q, 32'h0);
        @(posedge clk); #1;
        check("release_alu_q", alu_result_q, 32'hCAFE_F00E);
        check("release_store_q", store_data_q, 32'hCAFE_F00D);

        // Compares
        drive(2'b10, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check_alu("slt", 4'b0111, 32'h1);
        drive(2'b10, 4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check_alu("sltu", 4'b1001, 32'h0);
        drive(2'b11, 4'b1010, 1'b1, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'h0);
        check_alu("slti_bit3_ignored", 4'b0111, 32'h1);

        // Logic ops
        drive(2'b10, 4'b0111, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 32'h0);
        check_alu("and", 4'b0000, 32'h00F0_000F);
        drive(2'b10, 4'b0110, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 32'h0);
        check_alu("or", 4'b0001, 32'hFFF0_0FFF);
        drive(2'b10, 4'b0100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 32'h0);
        check_alu("xor", 4'b0011, 32'hFF00_0FF0);

        // Add wrap, default decode, ADDI with instr[30] set
        drive(2'b10, 4'b0000, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
        check_alu("add_wrap", 4'b0010, 32'h1);
        drive(2'b10, 4'b1001, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0);
        check_alu("r_default_add", 4'b0010, 32'd7);
        drive(2'b11, 4'b1000, 1'b1, 32'h10, 32'h55, 32'hFFFF_FFFF, 32'h0);
        check_alu("addi_bit30", 4'b0010, 32'hF);

        // Shifts
        drive(2'b11, 4'b1101, 1'b1, 32'h8000_0000, 32'h0, 32'h4, 32'h0);
        check_alu("srai", 4'b1000, exp_sra);
        drive(2'b11, 4'b0101, 1'b1, 32'h8000_0000, 32'h0, 32'h4, 32'h0);
        check_alu("srli", 4'b0101, exp_srl);
        drive(2'b10, 4'b0001, 1'b0, 32'h1, 32'h24, 32'h0, 32'h0);
        check_alu("sll_shamt", 4'b0100, exp_sll);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
